// File: rtl/accu_arbiter_pkg.sv
// Shared constants for the accumulator arbiter: state codes, default requester count
// and the round-robin index wrap helper.
package accu_arbiter_pkg;

    localparam int unsigned N_REQ_DEFAULT = 3;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_GRANT  = 3'd1;
    localparam logic [2:0] ST_ISSUE  = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_REPORT = 3'd4;

    typedef logic [1:0] idx_t;

    function automatic idx_t rr_wrap(input int unsigned base, input int unsigned n);
        return idx_t'(base % n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at ptr, ptr+1, ... modulo N_REQ.
module rr_pick
    import accu_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEFAULT
) (
    input  logic [N_REQ-1:0] req,
    input  idx_t             ptr,
    output logic             valid,
    output idx_t             idx
);

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            if (!valid && req[rr_wrap(32'(ptr) + off, N_REQ)]) begin
                valid = 1'b1;
                idx   = rr_wrap(32'(ptr) + off, N_REQ);
            end
        end
    end

endmodule

// File: rtl/accu_arbiter.sv
// Round-robin arbiter that feeds one granted data bit per transaction into an external
// count-to-4 accumulator and reports which requester completed the count.
module accu_arbiter
    import accu_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] req_bit,
    input  logic             acc_done,
    output logic [N_REQ-1:0] gnt,
    output logic             acc_next,
    output logic             acc_in,
    output logic             done_valid,
    output idx_t             done_id,
    output logic             busy,
    output logic [2:0]       state_display
);

    logic [2:0]       r_state;
    idx_t             r_ptr;
    idx_t             r_sel;
    logic [N_REQ-1:0] r_gnt;
    logic             r_acc_next;
    logic             r_acc_in;
    logic             r_done_valid;
    idx_t             r_done_id;
    logic             r_busy;

    logic             w_valid;
    idx_t             w_idx;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req   (req),
        .ptr   (r_ptr),
        .valid (w_valid),
        .idx   (w_idx)
    );

    // Every output is set on the edge that enters the state it belongs to, so all
    // outputs come straight from flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_sel        <= '0;
            r_gnt        <= '0;
            r_acc_next   <= 1'b0;
            r_acc_in     <= 1'b0;
            r_done_valid <= 1'b0;
            r_done_id    <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_gnt        <= '0;
            r_acc_next   <= 1'b0;
            r_done_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_state  <= ST_GRANT;
                        r_sel    <= w_idx;
                        r_ptr    <= rr_wrap(32'(w_idx) + 1, N_REQ);
                        r_gnt    <= N_REQ'(1) << w_idx;
                        r_acc_in <= req_bit[w_idx];
                        r_busy   <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    r_state    <= ST_ISSUE;
                    r_acc_next <= 1'b1;
                end
                ST_ISSUE: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (acc_done) begin
                        r_state      <= ST_REPORT;
                        r_done_valid <= 1'b1;
                        r_done_id    <= r_sel;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_REPORT: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    // Unused codes recover to IDLE with outputs back at their reset values.
                    r_state   <= ST_IDLE;
                    r_acc_in  <= 1'b0;
                    r_done_id <= '0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign gnt           = r_gnt;
    assign acc_next      = r_acc_next;
    assign acc_in        = r_acc_in;
    assign done_valid    = r_done_valid;
    assign done_id       = r_done_id;
    assign busy          = r_busy;
    assign state_display = r_state;

endmodule

// File: tb/tb_accu_arbiter.sv
// Scoreboard bench for accu_arbiter with a count-to-4 accumulator model on the strobe side.
module tb_accu_arbiter;

    logic       clk;
    logic       reset;
    logic [2:0] req;
    logic [2:0] req_bit;
    logic       acc_done;
    logic [2:0] gnt;
    logic       acc_next;
    logic       acc_in;
    logic       done_valid;
    logic [1:0] done_id;
    logic       busy;
    logic [2:0] state_display;

    accu_arbiter #(
        .N_REQ (3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .req_bit       (req_bit),
        .acc_done      (acc_done),
        .gnt           (gnt),
        .acc_next      (acc_next),
        .acc_in        (acc_in),
        .done_valid    (done_valid),
        .done_id       (done_id),
        .busy          (busy),
        .state_display (state_display)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count-to-4 accumulator: acc_done is registered, so it is valid the cycle after acc_next.
    int acc_cnt;
    always @(posedge clk) begin
        if (reset) begin
            acc_cnt  <= 0;
            acc_done <= 1'b0;
        end else begin
            acc_done <= 1'b0;
            if (acc_next && acc_in) begin
                if (acc_cnt == 3) begin
                    acc_cnt  <= 0;
                    acc_done <= 1'b1;
                end else begin
                    acc_cnt <= acc_cnt + 1;
                end
            end
        end
    end

    typedef struct {
        int kind;  // 0 grant vector, 1 acc_next with acc_in, 2 done with done_id
        int val;
    } ev_t;

    ev_t q[$];
    int  n_checks = 0;
    int  n_fail = 0;
    int  cyc = 0;
    int  g_count = 0;
    int  last_gnt_cyc = -100;
    int  last_acc_cyc = -100;
    int  last_done_cyc = -100;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        q.push_back(e);
    endtask

    // Monitor: pops the scoreboard on every observable event.
    always @(negedge clk) begin
        int   kind;
        int   val;
        ev_t  e;
        if (gnt != 3'b000 || acc_next || done_valid) begin
            check("single_event", int'(gnt != 3'b000) + int'(acc_next) + int'(done_valid), 1);
            if (gnt != 3'b000) begin
                kind = 0;
                val  = int'(gnt);
                check("gnt_spacing", int'((cyc - last_gnt_cyc) >= 4), 1);
                last_gnt_cyc = cyc;
                g_count++;
            end else if (acc_next) begin
                kind = 1;
                val  = int'(acc_in);
                last_acc_cyc = cyc;
            end else begin
                kind = 2;
                val  = int'(done_id);
                last_done_cyc = cyc;
            end
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: got kind %0d value %0d, expected none", kind,
                         val);
            end else begin
                e = q.pop_front();
                check("event_kind", kind, e.kind);
                check("event_value", val, e.val);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Hold a request pattern until n grants are seen, then drop req and disturb req_bit.
    task automatic serve(input logic [2:0] rq, input logic [2:0] bits, input int n);
        int start;
        start   = g_count;
        req     = rq;
        req_bit = bits;
        for (int c = 0; c < 100 && (g_count - start) < n; c++) tick();
        if ((g_count - start) < n) check("grant_timeout", g_count - start, n);
        req     = 3'b000;
        req_bit = ~bits;
        for (int c = 0; c < 20 && busy; c++) tick();
        if (busy) check("idle_timeout", int'(busy), 0);
        tick();
    endtask

    initial begin
        reset   = 1'b1;
        req     = 3'b000;
        req_bit = 3'b000;
        repeat (3) tick();
        check("rst_gnt", int'(gnt), 0);
        check("rst_acc_next", int'(acc_next), 0);
        check("rst_acc_in", int'(acc_in), 0);
        check("rst_done_valid", int'(done_valid), 0);
        check("rst_done_id", int'(done_id), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_state", int'(state_display), 0);
        reset = 1'b0;
        tick();

        // Single requester, four 1-bits complete the count.
        for (int i = 0; i < 4; i++) begin
            push(0, 1);
            push(1, 1);
        end
        push(2, 0);
        serve(3'b001, 3'b001, 4);

        // Contention from ptr=1 after the previous grant to 0... reset to get ptr=0 first.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        push(0, 1); push(1, 0);
        push(0, 2); push(1, 0);
        push(0, 4); push(1, 0);
        push(0, 1); push(1, 0);
        serve(3'b111, 3'b000, 4);

        // Fairness: grant to 1 moves ptr to 2, so 3'b011 wraps to 0.
        push(0, 2); push(1, 1);
        serve(3'b010, 3'b111, 1);
        push(0, 1); push(1, 1);
        serve(3'b011, 3'b111, 1);

        // Zero bits never complete the count (count sits at 2).
        for (int i = 0; i < 3; i++) begin
            push(0, 4);
            push(1, 0);
        end
        serve(3'b100, 3'b000, 3);

        // Two more 1-bits reach 4 with requester 2.
        push(0, 4); push(1, 1);
        push(0, 4); push(1, 1);
        push(2, 2);
        serve(3'b100, 3'b100, 2);
        check("lat_acc_after_gnt", last_acc_cyc - last_gnt_cyc, 1);
        check("lat_done_after_gnt", last_done_cyc - last_gnt_cyc, 3);
        repeat (2) tick();
        check("done_id_hold", int'(done_id), 2);

        // Bring count to 3, then reset in WAIT while the fourth bit would complete it.
        for (int i = 0; i < 3; i++) begin
            push(0, 1);
            push(1, 1);
        end
        serve(3'b001, 3'b001, 3);
        push(0, 1); push(1, 1);
        req     = 3'b001;
        req_bit = 3'b001;
        for (int c = 0; c < 30 && state_display != 3'd3; c++) begin
            tick();
            if (gnt != 3'b000) req = 3'b000;
        end
        check("reach_wait", int'(state_display), 3);
        reset = 1'b1;
        tick();
        check("abort_state", int'(state_display), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done_valid", int'(done_valid), 0);
        check("abort_done_id", int'(done_id), 0);
        reset = 1'b0;
        tick();
        // ptr back at 0 picks requester 0 out of 3'b101.
        push(0, 1); push(1, 0);
        serve(3'b101, 3'b000, 1);

        // Illegal state code recovers to IDLE.
        force dut.r_state = 3'd6;
        #1;
        release dut.r_state;
        check("forced_state", int'(state_display), 6);
        tick();
        check("illegal_state", int'(state_display), 0);
        check("illegal_busy", int'(busy), 0);
        check("illegal_gnt", int'(gnt), 0);
        check("illegal_acc_next", int'(acc_next), 0);
        check("illegal_done_valid", int'(done_valid), 0);
        repeat (3) tick();

        check("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/accu_arbiter.md
ACCU_ARBITER -- requirements
Module: accu_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 3, meaning number of requesters (legal range 2..4).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req  input  N_REQ  per-requester request, held high until granted.
REQ-005 SHALL have port req_bit  input  N_REQ  per-requester data bit to push into the accumulator.
REQ-006 SHALL have port acc_done  input  1  accumulator count-reached-4 flag, valid the cycle after an acc_next strobe.
REQ-007 SHALL have port gnt  output  N_REQ  one-hot grant pulse.
REQ-008 SHALL have port acc_next  output  1  one-cycle strobe to the accumulator.
REQ-009 SHALL have port acc_in  output  1  data bit presented with acc_next.
REQ-010 SHALL have port done_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port done_id  output  2  index of the requester whose bit completed the count.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port state_display  output  3  current state encoding.

Function
REQ-014 SHALL implement states IDLE=0, GRANT=1, ISSUE=2, WAIT=3, REPORT=4; codes 5..7 SHALL go to IDLE on the next edge.
REQ-015 SHALL drive all outputs from registers, with no combinational path from inputs to outputs.
REQ-016 IDLE: if any req bit is high, SHALL select a winner by round-robin starting at pointer ptr, latch its index as sel, and enter GRANT; otherwise SHALL stay in IDLE.
REQ-017 Round-robin: winner is the first high req at index ptr, ptr+1, ... mod N_REQ; ptr SHALL become (sel+1) mod N_REQ on entry to GRANT.
REQ-018 GRANT: gnt[sel]=1 for exactly one cycle, req_bit[sel] latched into acc_in in that same cycle, next state ISSUE.
REQ-019 ISSUE: acc_next=1 for exactly one cycle, acc_in stable, next state WAIT.
REQ-020 WAIT: SHALL sample acc_done; 1 -> REPORT, 0 -> IDLE.
REQ-021 REPORT: done_valid=1 and done_id=sel for one cycle, then IDLE.
REQ-022 done_id SHALL hold its last value when done_valid=0.
REQ-023 A req still high after its grant pulse SHALL be treated as a new request.
REQ-024 A req that drops before it is granted SHALL be ignored without error.
REQ-025 Latency: req high at edge k (in IDLE) SHALL give gnt at k+1, acc_next at k+2, and done_valid (if any) at k+4; minimum service interval 4 cycles without REPORT, 5 with.
REQ-026 Changes on req or req_bit outside IDLE/GRANT sampling SHALL have no effect on the transaction in flight.
REQ-027 At most one of gnt, acc_next and done_valid SHALL be high in any cycle.

Reset
REQ-028 On reset: state=IDLE, ptr=0, sel=0, gnt=0, acc_next=0, acc_in=0, done_valid=0, done_id=0, busy=0, state_display=0.
REQ-029 Reset asserted mid-transaction SHALL abort it, and no acc_next or done_valid SHALL be issued for the aborted grant.
REQ-030 Reset SHALL take priority over all transitions.

Structure
REQ-031 A shared package SHALL hold the state encoding constants and the N_REQ default.
REQ-032 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs req and ptr; outputs valid and idx).
REQ-033 The accumulator itself SHALL NOT be included; the bench SHALL connect a count-to-4 reference model.

Verification
REQ-034 Single requester: req=3'b001, req_bit=1, four transactions -> four gnt[0] pulses, and done_valid with done_id=0 after the fourth.
REQ-035 Contention: req=3'b111 held, ptr=0 -> grant order 0,1,2,0; each gnt at least 4 cycles apart.
REQ-036 Pointer fairness: a grant to 1, then req=3'b011 -> next grant goes to 0 (ptr=2 wraps to 0).
REQ-037 Zero bits: req_bit=0 on all transactions -> acc_next pulses with acc_in=0 and done_valid never high.
REQ-038 Reset during WAIT -> next cycle state_display=0, no done_valid, ptr=0.
REQ-039 Illegal state forced to 6 -> IDLE on the next edge, with outputs at their reset values.
